// File: rtl/qrs_rpeak_detector_p.sv
// Streaming ECG R-peak detector: |first difference| -> moving-window integrator -> adaptive
// threshold with refractory FSM. Define QRS_THR_DECAY_EN to add idle-time threshold decay.
module qrs_rpeak_detector_p #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned INIT_THR = 32'h0200,
  parameter int unsigned THR_MIN  = 32'h0040,
  parameter int unsigned REFRACT  = 100,
  parameter int unsigned RR_W     = 16,
  parameter int unsigned RR_MAX   = 400
) (
  input  logic              clock_iht,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x,
  input  logic              x_valid,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_amp,
  output logic [RR_W-1:0]   rr_interval,
  output logic [DATA_W:0]   thr,
  output logic [1:0]        yesnoaddr_R_peak
);
  localparam int unsigned NTap      = 1 << WIN_LOG2;
  localparam int unsigned SumW      = DATA_W + 1 + WIN_LOG2;
  localparam int unsigned CntW      = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam int unsigned RefractM1 = REFRACT - 1;
  localparam logic [CntW-1:0] RefractLoad = RefractM1[CntW-1:0];
  localparam logic [DATA_W:0] InitThr = INIT_THR[DATA_W:0];
  localparam logic [DATA_W:0] ThrMin  = THR_MIN[DATA_W:0];

  localparam logic [1:0] StIdle    = 2'b00;
  localparam logic [1:0] StCand    = 2'b01;
  localparam logic [1:0] StRefract = 2'b11;

  logic [DATA_W-1:0]            x_prev_q, x_prev_d;
  logic [DATA_W:0]              e_q, e_d;
  logic [NTap-1:0][DATA_W:0]    taps_q, taps_d;
  logic [SumW-1:0]              sum_q, sum_d;
  logic [1:0]                   state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]            amp_max_q, amp_max_d;
  logic [DATA_W:0]              m_max_q, m_max_d;
  logic [RR_W-1:0]              rr_q, rr_d;
  logic                         peak_valid_q, peak_valid_d;
  logic [DATA_W-1:0]            peak_amp_q, peak_amp_d;
  logic [RR_W-1:0]              rr_interval_q, rr_interval_d;
  logic [DATA_W:0]              thr_q, thr_d;

  logic [DATA_W:0]   diff, e_new, m, m_max_nxt, thr_raw, thr_pk;
  logic [DATA_W-1:0] amp_nxt;

`ifdef QRS_THR_DECAY_EN
  localparam int unsigned DcntW    = (RR_MAX > 1) ? $clog2(RR_MAX) : 1;
  localparam int unsigned RrMaxM1  = RR_MAX - 1;
  localparam logic [DcntW-1:0] DcntLast = RrMaxM1[DcntW-1:0];
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic [DATA_W:0]  thr_half;
`endif

  // Sign-extended difference cannot overflow; negating the most negative value wraps onto
  // the correct unsigned magnitude.
  assign diff  = {x[DATA_W-1], x} - {x_prev_q[DATA_W-1], x_prev_q};
  assign e_new = diff[DATA_W] ? (~diff + 1'b1) : diff;
  assign m     = sum_q[SumW-1:WIN_LOG2];

  always_comb begin
    x_prev_d      = x_prev_q;
    e_d           = e_q;
    taps_d        = taps_q;
    sum_d         = sum_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    amp_max_d     = amp_max_q;
    m_max_d       = m_max_q;
    rr_d          = rr_q;
    peak_valid_d  = 1'b0;
    peak_amp_d    = peak_amp_q;
    rr_interval_d = rr_interval_q;
    thr_d         = thr_q;
    amp_nxt       = ($signed(x) > $signed(amp_max_q)) ? x : amp_max_q;
    m_max_nxt     = (m > m_max_q) ? m : m_max_q;
    thr_raw       = thr_q - (thr_q >> 2) + (m_max_nxt >> 3);
    thr_pk        = (thr_raw < ThrMin) ? ThrMin : thr_raw;
`ifdef QRS_THR_DECAY_EN
    dcnt_d        = dcnt_q;
    thr_half      = ((thr_q >> 1) < ThrMin) ? ThrMin : (thr_q >> 1);
`endif
    if (x_valid) begin
      x_prev_d  = x;
      e_d       = e_new;
      taps_d[0] = e_q;
      for (int i = 1; i < NTap; i++) taps_d[i] = taps_q[i-1];
      sum_d = sum_q + SumW'(e_q) - SumW'(taps_q[NTap-1]);
      if (rr_q != {RR_W{1'b1}}) rr_d = rr_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (m > thr_q) begin
            state_d   = StCand;
            amp_max_d = x;
            m_max_d   = m;
`ifdef QRS_THR_DECAY_EN
            dcnt_d    = '0;
          end else if (dcnt_q == DcntLast) begin
            thr_d  = thr_half;
            dcnt_d = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
`endif
          end
        end
        StCand: begin
          amp_max_d = amp_nxt;
          m_max_d   = m_max_nxt;
          if (m <= thr_q) begin
            peak_valid_d  = 1'b1;
            peak_amp_d    = amp_nxt;
            rr_interval_d = rr_q;
            rr_d          = RR_W'(1);
            thr_d         = thr_pk;
            state_d       = StRefract;
            cnt_d         = RefractLoad;
`ifdef QRS_THR_DECAY_EN
            dcnt_d        = '0;
`endif
          end
        end
        StRefract: begin
          if (cnt_q == '0) state_d = StIdle;
          else cnt_d = cnt_q - 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock_iht or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q      <= '0;
      e_q           <= '0;
      taps_q        <= '0;
      sum_q         <= '0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      amp_max_q     <= '0;
      m_max_q       <= '0;
      rr_q          <= '0;
      peak_valid_q  <= 1'b0;
      peak_amp_q    <= '0;
      rr_interval_q <= '0;
      thr_q         <= InitThr;
`ifdef QRS_THR_DECAY_EN
      dcnt_q        <= '0;
`endif
    end else begin
      x_prev_q      <= x_prev_d;
      e_q           <= e_d;
      taps_q        <= taps_d;
      sum_q         <= sum_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      amp_max_q     <= amp_max_d;
      m_max_q       <= m_max_d;
      rr_q          <= rr_d;
      peak_valid_q  <= peak_valid_d;
      peak_amp_q    <= peak_amp_d;
      rr_interval_q <= rr_interval_d;
      thr_q         <= thr_d;
`ifdef QRS_THR_DECAY_EN
      dcnt_q        <= dcnt_d;
`endif
    end
  end

  assign peak_valid       = peak_valid_q;
  assign peak_amp         = peak_amp_q;
  assign rr_interval      = rr_interval_q;
  assign thr              = thr_q;
  assign yesnoaddr_R_peak = peak_valid_q ? 2'b10 : state_q;

endmodule

// File: doc/qrs_rpeak_detector_p.md
Name: qrs_rpeak_detector_p

Overview:
- Parametrised second-generation R-peak detector for the ECG path: streaming signed samples in, one-cycle R-peak event out.
- Carries peak amplitude and RR interval with the event.
- Processing: sample-valid qualified first difference, absolute value, moving-window integration, adaptive threshold and refractory FSM.
- Keeps the 2-bit status output of the previous detector and adds a valid strobe, reset and configurability.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- WIN_LOG2, 3, integration window = 2^WIN_LOG2 samples
- INIT_THR, 16'h0200, threshold after reset (width DATA_W+1, zero-extended)
- THR_MIN, 16'h0040, decay floor for threshold
- REFRACT, 100, refractory length in valid samples
- RR_W, 16, RR interval counter width (saturating)
- RR_MAX, 400, samples without a peak before threshold decay (optional feature)

Ports:
- clock_iht  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- x  in  DATA_W  signed ECG sample
- x_valid  in  1  sample strobe; all processing state advances only when high
- peak_valid  out  1  one-cycle pulse, R peak detected
- peak_amp  out  DATA_W  max signed x within candidate, held until next peak
- rr_interval  out  RR_W  valid samples since previous peak, held until next peak
- thr  out  DATA_W+1  current threshold
- yesnoaddr_R_peak  out  2  status: 00 IDLE, 01 CAND, 10 peak pulse cycle, 11 REFRACT

Behaviour:
- Reset values, async on rst_n low:
  - outputs: peak_valid=0, peak_amp=0, rr_interval=0, thr=INIT_THR, yesnoaddr_R_peak=00
  - internal state: x_prev, window taps and sum = 0; FSM=IDLE; rr counter=0
- Pipeline, advancing on x_valid only:
  - d = x - x_prev, DATA_W+1 signed, no overflow
  - e = |d|, DATA_W+1 unsigned; |min| representable
  - sum += e_new - e_oldest over 2^WIN_LOG2 taps, DATA_W+1+WIN_LOG2 bits
  - m = sum >> WIN_LOG2
  - Latency x -> m: 2 valid samples (e registered, sum registered)
- FSM, evaluated on x_valid cycles only:
  - IDLE: m > thr (strict) -> CAND; load amp_max=x.
  - CAND: amp_max=max(amp_max,x) signed; track m_max. m <= thr -> emit peak, -> REFRACT; load refract counter=REFRACT-1.
  - REFRACT: counter decrements per valid sample; m ignored; at 0 -> IDLE.
- Peak emission, same edge as the CAND->REFRACT transition:
  - peak_valid=1 for exactly one clock
  - peak_amp=amp_max
  - rr_interval=rr counter; rr counter cleared to 1 if x_valid, else 0
  - thr = thr - (thr>>2) + (m_max>>3); equilibrium m_max/2; result clamped to >= THR_MIN
- RR counter: +1 per valid sample, saturates at 2^RR_W-1, never wraps.
- x_valid low: all state frozen, peak_valid low after its one cycle.
- Status: yesnoaddr_R_peak=10 only in the peak_valid cycle; otherwise it encodes the FSM state.
- rst_n asserted mid-CAND or mid-REFRACT: immediate return to reset values. No peak is emitted for the aborted candidate.

Optional Feature:
- Macro QRS_THR_DECAY_EN.
- Defined:
  - Separate decay counter increments per valid sample in IDLE; cleared on any peak and on entering CAND.
  - Reaching RR_MAX: thr = max(thr>>1, THR_MIN), counter cleared, repeats every RR_MAX idle samples.
- Undefined: counter absent, thr changes only on peaks.

Test Plan:
- Reset: hold rst_n=0 with x toggling -> all outputs at reset values. thr=0x0200, yesnoaddr_R_peak=00.
- Noise: x alternating +0x0040/-0x0040 for 500 valid samples -> m=0x0080, never peak_valid, status stays 00.
- Single pulse, then flat 0:
  - Stimulus: 20 samples of 0; x rises 0x0400/sample to 0x3000 (12 steps); falls 0x0400/sample to 0.
  - Response: exactly one peak_valid after m drops; peak_amp=0x3000, thr stays 0x0200, status goes 01 -> 10 -> 11 -> 00.
- Refractory and RR:
  - Stimulus: same pulse repeated every 300 samples, plus one extra pulse 60 samples after the second peak.
  - Response: extra pulse ignored (status 11 throughout); third peak rr_interval=300.
- x_valid gaps plus mid-operation reset:
  - Single pulse with x_valid low every other cycle -> identical peak_amp/rr_interval to the gapless run.
  - rst_n pulsed during CAND -> no peak_valid; outputs at reset values.
- With QRS_THR_DECAY_EN: thr preset to 0x0200 by one pulse, then flat input -> thr=0x0100 after 400 idle samples, 0x0080 after 800, 0x0040 after 1200 and held. Without the macro thr stays 0x0200.
